// File: rtl/sub_cmp_pipe_if.sv
// sub_cmp_pipe_if: operand/result handshake bundle for sub_cmp_pipe.
//   in_valid/in_ready   operation offered / accepted
//   in_a, in_b          minuend / subtrahend (WIDTH)
//   in_sign             1 = signed, 0 = unsigned
//   in_tag              opaque tag (TAG_W), returned with the result
//   out_valid/out_ready result present / consumed
//   out_s               A - B mod 2^WIDTH
//   out_z/v/n/lt        zero, overflow/borrow, negative, less-than
//   out_tag             tag of the result
// master = producer/consumer side (issue + writeback), slave = the pipe.
interface sub_cmp_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sign;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_z;
  logic             out_v;
  logic             out_n;
  logic             out_lt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sign, in_tag, out_ready,
    input  in_ready, out_valid, out_s, out_z, out_v, out_n, out_lt, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sign, in_tag, out_ready,
    output in_ready, out_valid, out_s, out_z, out_v, out_n, out_lt, out_tag
  );
endinterface

// File: rtl/sub_cmp_pipe.sv
// sub_cmp_pipe: pipelined subtract/compare. S = A - B is computed in STAGES
// borrow-chained slices of W_S = WIDTH/STAGES bits, one slice per stage.
// The last stage derives Z/V/N/lt from the full result and registers them.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          sub_cmp_pipe_if.slave (operand in / result out handshake)
//   v_clr        (SUB_CMP_PIPE_STICKY_V_EN only) clear sticky overflow
//   v_sticky     (SUB_CMP_PIPE_STICKY_V_EN only) sticky overflow flag
// Optional feature macro: SUB_CMP_PIPE_STICKY_V_EN.
// Whole pipe advances together on adv = !out_valid || out_ready; bubbles stay.

// One borrow-chained slice of the subtractor.
module sub_cmp_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);
  logic [W:0] diff;

  // Extra top bit goes to 1 exactly when the slice underflows.
  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = diff[W-1:0];
  assign bout = diff[W];
endmodule

module sub_cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  sub_cmp_pipe_if.slave bus
`ifdef SUB_CMP_PIPE_STICKY_V_EN
  ,
  input  logic          v_clr,
  output logic          v_sticky
`endif
);
  localparam int W_S = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  // Operands travel whole; bits already consumed have no fanout downstream
  // and are trimmed by synthesis.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             borrow;
    logic             sign;
    logic [TAG_W-1:0] tag;
    logic             z;
    logic             v;
    logic             n;
    logic             lt;
  } stage_t;

  logic              adv;
  logic              vld_in;
  logic [STAGES:1]   vld_pipe;
  logic [STAGES:0]   vld_shift;

  stage_t stg_cur [STAGES];
  stage_t stg_nxt [STAGES];
  stage_t stg_q   [STAGES];

  // Backpressure depends only on the output register, never on in_valid.
  assign adv          = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = adv;
  assign vld_in       = bus.in_valid && adv;
  assign vld_shift    = {vld_pipe, vld_in};

  always_ff @(posedge clk) begin
    if (reset)    vld_pipe <= '0;
    else if (adv) vld_pipe <= vld_shift[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [W_S-1:0] d;
    logic           bout;

    if (k == 0) begin : g_head
      always_comb begin
        stg_cur[0]      = '0;
        stg_cur[0].a    = bus.in_a;
        stg_cur[0].b    = bus.in_b;
        stg_cur[0].sign = bus.in_sign;
        stg_cur[0].tag  = bus.in_tag;
      end
    end else begin : g_body
      assign stg_cur[k] = stg_q[k-1];
    end

    sub_cmp_slice #(.W(W_S)) u_slice (
      .a    (stg_cur[k].a[k*W_S +: W_S]),
      .b    (stg_cur[k].b[k*W_S +: W_S]),
      .bin  (stg_cur[k].borrow),
      .d    (d),
      .bout (bout)
    );

    always_comb begin
      stg_nxt[k]                 = stg_cur[k];
      stg_nxt[k].s[k*W_S +: W_S] = d;
      stg_nxt[k].borrow          = bout;
      if (k == STAGES - 1) begin
        stg_nxt[k].z = (stg_nxt[k].s == '0);
        if (stg_cur[k].sign) begin
          // Overflow: operands differ in sign and result sign left A's.
          stg_nxt[k].v  = (stg_cur[k].a[MSB] != stg_cur[k].b[MSB]) &&
                          (stg_nxt[k].s[MSB] != stg_cur[k].a[MSB]);
          stg_nxt[k].n  = stg_nxt[k].s[MSB];
          stg_nxt[k].lt = stg_nxt[k].s[MSB] ^ stg_nxt[k].v;
        end else begin
          // Final borrow-out is the unsigned A < B.
          stg_nxt[k].v  = bout;
          stg_nxt[k].n  = 1'b0;
          stg_nxt[k].lt = bout;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset)    stg_q[k] <= '0;
      else if (adv) stg_q[k] <= stg_nxt[k];
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_s     = stg_q[STAGES-1].s;
  assign bus.out_z     = stg_q[STAGES-1].z;
  assign bus.out_v     = stg_q[STAGES-1].v;
  assign bus.out_n     = stg_q[STAGES-1].n;
  assign bus.out_lt    = stg_q[STAGES-1].lt;
  assign bus.out_tag   = stg_q[STAGES-1].tag;

`ifdef SUB_CMP_PIPE_STICKY_V_EN
  // Set on a consumed result with overflow; set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                                         v_sticky <= 1'b0;
    else if (bus.out_valid && bus.out_ready && bus.out_v) v_sticky <= 1'b1;
    else if (v_clr)                                    v_sticky <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_sub_cmp_pipe.sv
module tb_sub_cmp_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  typedef struct {
    logic [31:0] s;
    logic        z, v, n, lt;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic reset;
`ifdef SUB_CMP_PIPE_STICKY_V_EN
  logic v_clr;
  logic v_sticky;
  logic exp_sticky;
`endif

  sub_cmp_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  sub_cmp_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus)
`ifdef SUB_CMP_PIPE_STICKY_V_EN
    ,
    .v_clr    (v_clr),
    .v_sticky (v_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_out  = 0;
  exp_t        exp_q [$];
  logic        hold_pend = 1'b0;
  logic [39:0] held;
  logic        in_fire, last_in_ready;
  logic [31:0] last_s;
  logic [3:0]  last_f, last_tag;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t ref_calc(input logic [31:0] a, input logic [31:0] b,
                                    input logic sg, input logic [3:0] tag);
    exp_t   e;
    longint sa, sb, d;
    e.s   = a - b;
    e.z   = (e.s == 32'd0);
    e.tag = tag;
    if (sg) begin
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      d    = sa - sb;
      e.v  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      e.n  = e.s[31];
      e.lt = (sa < sb);
    end else begin
      e.v  = (a < b);
      e.n  = 1'b0;
      e.lt = (a < b);
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0001_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge after inputs are driven; checks this cycle, then
  // advances to the next negedge.
  task automatic tick();
    exp_t e;
    logic set_v;
    #1;
    set_v   = 1'b0;
    in_fire = 1'b0;
    if (!reset) begin
      last_in_ready = bus.in_ready;
      chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
`ifdef SUB_CMP_PIPE_STICKY_V_EN
      chk("v_sticky", v_sticky, exp_sticky);
`endif
      if (hold_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_lt, bus.out_tag}, held);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        chk("out_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_s", bus.out_s, e.s);
          chk("out_flags", {bus.out_z, bus.out_v, bus.out_n, bus.out_lt}, {e.z, e.v, e.n, e.lt});
          chk("out_tag", bus.out_tag, e.tag);
          set_v = e.v;
        end
        last_s   = bus.out_s;
        last_f   = {bus.out_z, bus.out_v, bus.out_n, bus.out_lt};
        last_tag = bus.out_tag;
      end
`ifdef SUB_CMP_PIPE_STICKY_V_EN
      if (set_v)      exp_sticky = 1'b1;
      else if (v_clr) exp_sticky = 1'b0;
`endif
      hold_pend = bus.out_valid && !bus.out_ready;
      held      = {bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_lt, bus.out_tag};
      in_fire   = bus.in_valid && bus.in_ready;
      if (in_fire) exp_q.push_back(ref_calc(bus.in_a, bus.in_b, bus.in_sign, bus.in_tag));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    hold_pend = 1'b0;
    exp_q.delete();
`ifdef SUB_CMP_PIPE_STICKY_V_EN
    exp_sticky = 1'b0;
`endif
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sg, input logic [3:0] tag);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_sign   = sg;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic [31:0] s_exp, input logic [3:0] f_exp);
    send(a, b, sg, 4'hA);
    drain();
    chk({nm, "_s"}, last_s, s_exp);
    chk({nm, "_zvnlt"}, last_f, f_exp);
  endtask

  initial begin
    int lat, c, nxt, base, g;
    logic [31:0] sa_arr [8];
    logic [31:0] sb_arr [8];

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sign   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
`ifdef SUB_CMP_PIPE_STICKY_V_EN
    v_clr      = 1'b0;
    exp_sticky = 1'b0;
`endif
    do_reset(3);

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_s", bus.out_s, 0);
    chk("rst_flags", {bus.out_z, bus.out_v, bus.out_n, bus.out_lt}, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef SUB_CMP_PIPE_STICKY_V_EN
    chk("rst_sticky", v_sticky, 0);
`endif

    // Latency with continuous out_ready
    send(32'd5, 32'd7, 1'b0, 4'h3);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, STAGES);
    drain();
    chk("u5m7_s", last_s, 32'hFFFF_FFFE);
    chk("u5m7_zvnlt", last_f, 4'b0101);
    chk("u5m7_tag", last_tag, 4'h3);

    // Directed corner cases
    directed("s_min_m1",  32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0101);
    directed("s_max_mn1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 4'b0110);
    directed("eq_u",      32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 32'h0,         4'b1000);
    directed("eq_s",      32'h1234_ABCD, 32'h1234_ABCD, 1'b1, 32'h0,         4'b1000);
    directed("borrow",    32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 4'b0000);

    // Stream of 8 tagged ops, consumer stalls cycles 3..5
    for (int i = 0; i < 8; i++) begin
      sa_arr[i] = pick();
      sb_arr[i] = pick();
    end
    base = n_out;
    nxt  = 0;
    c    = 0;
    while ((n_out - base) < 8 && c < 60) begin
      bus.in_valid  = (nxt < 8);
      bus.in_a      = sa_arr[nxt & 7];
      bus.in_b      = sb_arr[nxt & 7];
      bus.in_sign   = nxt[0];
      bus.in_tag    = 4'(nxt);
      bus.out_ready = !(c >= 3 && c <= 5);
      tick();
      if (c >= 3 && c <= 5) chk("stall_in_ready", last_in_ready, 0);
      if (in_fire) nxt++;
      c++;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", n_out - base, 8);
    chk("stream_tag7", last_tag, 4'h7);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = pick();
      bus.in_b      = pick();
      bus.in_sign   = $urandom_range(0, 1);
      bus.in_tag    = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    drain();

`ifdef SUB_CMP_PIPE_STICKY_V_EN
    // Sticky overflow: persists across clean results until cleared
    directed("stk_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0101);
    chk("stk_after_ovf", v_sticky, 1);
    for (int i = 0; i < 3; i++) send(32'd9, 32'd4, 1'b1, 4'(i));
    drain();
    chk("stk_after_clean", v_sticky, 1);
    v_clr = 1'b1;
    tick();
    v_clr = 1'b0;
    chk("stk_cleared", v_sticky, 0);
    // Clear coincident with an overflow result: set wins
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h5);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      tick();
      g++;
    end
    chk("stk_wait", bus.out_valid, 1);
    v_clr = 1'b1;
    tick();
    v_clr = 1'b0;
    chk("stk_set_wins", v_sticky, 1);
    drain();
`endif

    // Reset with two ops in flight: nothing stale emerges
    send(32'd100, 32'd1, 1'b0, 4'hC);
    send(32'd200, 32'd2, 1'b0, 4'hD);
    do_reset(1);
    chk("flush_out_valid", bus.out_valid, 0);
`ifdef SUB_CMP_PIPE_STICKY_V_EN
    chk("flush_sticky", v_sticky, 0);
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", bus.out_valid, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_fail %0d", n_fail);
    $fatal(1);
  end
endmodule

// File: doc/sub_cmp_pipe.md
# sub_cmp_pipe

Parametrised, pipelined subtract/compare unit for the ALU datapath: computes S = A − B over WIDTH bits split into STAGES borrow-chained slices, one slice per pipeline stage, and produces Z/V/N flags plus a less-than result. Signed/unsigned flag semantics are the codebase's established ALU subtract semantics, generalised to any width. A valid/ready handshake on both sides lets it sit between the issue stage and the writeback/branch-resolve logic with backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 2, pipeline depth = number of slices (1..8); slice width W_S = WIDTH/STAGES
- TAG_W, 4, width of opaque tag carried alongside each operation
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_a  in  WIDTH  minuend
- in_b  in  WIDTH  subtrahend
- in_sign  in  1  1 = signed, 0 = unsigned
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_s  out  WIDTH  A − B mod 2^WIDTH
- out_z, out_v, out_n  out  1 each  flags
- out_lt  out  1  A < B under in_sign interpretation
- out_tag  out  TAG_W  tag of this result

## Operation
- Stage k (0-based) computes slice bits [k·W_S +: W_S] of A − B with borrow-in from stage k−1 (stage 0 borrow-in = 0); upper operand slices and already-computed lower result slices travel down the pipe.
- Flags computed in the last stage from the full S, final borrow-out, MSBs of A/B and sign:
  - Z = (S == 0), both modes.
  - Unsigned: N = 0; V = borrow-out (A < B unsigned); lt = V.
  - Signed: V = (A[MSB] != B[MSB]) && (S[MSB] != A[MSB]); N = S[MSB] (raw result sign, not corrected on overflow); lt = N ^ V.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv. When adv, every stage register (data + valid) shifts one stage; when !adv all stages hold. Bubbles are not squeezed out.
- Stage valid bits: stage 0 loads in_valid && in_ready; output register is last stage's.
- Output data, flags and tag must stay stable while out_valid && !out_ready.

## Timing
- Latency: exactly STAGES cycles from accept edge to out_valid with continuous out_ready.
- Throughput: one operation per cycle when out_ready held high.
- Reset: all stage valids 0; out_valid = 0; out_s = 0; out_z = out_v = out_n = out_lt = 0; out_tag = 0; in_ready = 1 in the cycle after reset deasserts (and during reset, since out_valid = 0). In-flight operations during reset are discarded, no partial result emerges.
- in_ready is combinational from out_valid/out_ready only; no path from in_valid to in_ready.
- Simultaneous accept and emit in one cycle with adv = 1 is normal; no hazard.
- STAGES = 1: single registered stage, latency 1.

## Configuration
- SUB_CMP_PIPE_STICKY_V_EN defined: adds ports v_clr (in, 1) and v_sticky (out, 1). v_sticky sets on each handshake-completed output (out_valid && out_ready) with out_v = 1; clears on reset or v_clr; set wins over clear in the same cycle. Reset value 0.
- Undefined: ports absent, no sticky register; all other behaviour identical.

## Test plan
- Unsigned, WIDTH 32, STAGES 2: A=5, B=7 -> after 2 cycles S=0xFFFFFFFE, Z0 V1 N0 lt1.
- Signed: A=0x80000000, B=1 -> S=0x7FFFFFFF, V1 N0 lt1; A=0x7FFFFFFF, B=0xFFFFFFFF -> S=0x80000000, V1 N1 lt0.
- Equal operands A=B=0x1234ABCD, both modes -> S=0, Z1 V0 N0 lt0; borrow across slice boundary A=0x00010000, B=1 -> S=0x0000FFFF.
- Stream 8 ops with tags 0..7, out_ready low cycles 3–5 -> in_ready low those cycles, outputs held stable, all 8 emerge in tag order, none lost or duplicated.
- Reset asserted 1 cycle with 2 ops in flight -> out_valid 0 next cycle, no stale result later; sticky (if enabled) 0.
- SUB_CMP_PIPE_STICKY_V_EN: overflow op then clean ops -> v_sticky stays 1 until v_clr; v_clr coincident with overflow output -> remains 1.
